fetch_queue: RTL

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 85 ++++++++
 rtl/fetch_queue.sv | 111 +++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared widths and the instruction-buffer entry type used by the fetch queue
// and its storage FIFO.
//   ADDR_W        : word-address width of the instruction memory (5)
//   INSTR_W       : instruction word width (32)
//   fetch_entry_t : {instr, pc} pair held in each buffer entry
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int ADDR_W  = 5;
    localparam int INSTR_W = 32;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } fetch_entry_t;

endpackage : fetch_pkg

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Circular instruction buffer with read/write pointers and an occupancy count.
// The head entry is presented combinationally from the storage array.
//   clock        : clock, all state on rising edge
//   reset_n      : asynchronous active-low reset
//   clear_i      : flush all entries (wins over push/pop)
//   push_i       : write push_entry_i at the tail
//   push_entry_i : entry to write
//   pop_i        : drop the head entry (ignored while empty)
//   head_o       : current head entry
//   count_o      : number of valid entries (0..DEPTH)
// -----------------------------------------------------------------------------
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       clear_i,
    input  logic                       push_i,
    input  fetch_entry_t               push_entry_i,
    input  logic                       pop_i,
    output fetch_entry_t               head_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_eff, pop_eff;
    logic [DEPTH-1:0] wr_en;

    // The caller never pushes into a full buffer, so only underflow needs guarding.
    assign push_eff = push_i && !clear_i;
    assign pop_eff  = pop_i && !clear_i && (count_q != '0);

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_dec
            assign wr_en[gi] = push_eff && (wr_ptr_q == PTR_W'(gi));
        end
    endgenerate

    // Entries are reset so the head reads as all-zero while in reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_en[i]) mem_q[i] <= push_entry_i;
            end
        end
    end

    always_comb begin
        count_d = count_q;
        if (push_eff && !pop_eff) count_d = count_q + CNT_W'(1);
        if (!push_eff && pop_eff) count_d = count_q - CNT_W'(1);
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_eff) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_eff)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule : fetch_fifo

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Instruction prefetch queue: issues sequential word reads to a memory with
// one-cycle read latency, buffers returned words with their addresses, and
// hands them to decode with a valid/ready handshake. A redirect flushes the
// buffer, drops any in-flight response and restarts fetch at a new address.
//   clock, reset_n        : clock / asynchronous active-low reset
//   imem_rd, imem_addr    : read request and word address (= fetch pointer)
//   imem_data             : read data, valid one cycle after imem_rd
//   redirect, redirect_addr : flush and restart fetch at redirect_addr
//   out_valid, out_ready  : head-entry handshake to decode
//   out_instr, out_pc     : head instruction and its word address
//   stall_cycles          : (only with FETCH_STALL_CNT_EN defined) saturating
//                           count of cycles where fetch was blocked
// -----------------------------------------------------------------------------
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = 5'd0
) (
    input  logic               clock,
    input  logic               reset_n,
    output logic               imem_rd,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_addr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [15:0]        stall_cycles
`endif
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] req_pc_q;
    logic              inflight_q;
    logic [CNT_W-1:0]  count;
    logic [CNT_W:0]    occupancy;
    logic              push, pop;
    fetch_entry_t      push_entry, head;

    // Occupancy counts the outstanding request so a full buffer can never be
    // overrun; a same-cycle pop is deliberately not credited.
    assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight_q};
    assign imem_rd   = reset_n && !redirect && (occupancy < (CNT_W+1)'(DEPTH));
    assign imem_addr = pc_q;

    always_comb begin
        pc_d = pc_q;
        if (redirect)     pc_d = redirect_addr;
        else if (imem_rd) pc_d = pc_q + ADDR_W'(1);
    end

    // A redirect never issues, so inflight drops to 0 and the response that
    // would have arrived next cycle is ignored.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_q       <= RESET_PC;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= imem_rd;
            if (imem_rd) req_pc_q <= pc_q;
        end
    end

    assign push             = inflight_q && !redirect;
    assign pop              = out_valid && out_ready;
    assign push_entry.instr = imem_data;
    assign push_entry.pc    = req_pc_q;

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock        (clock),
        .reset_n      (reset_n),
        .clear_i      (redirect),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .head_o       (head),
        .count_o      (count)
    );

    assign out_valid = (count != '0);
    assign out_instr = head.instr;
    assign out_pc    = head.pc;

`ifdef FETCH_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
        end else if (!redirect && !imem_rd && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cycles = stall_cnt_q;
`else
    // Stall counter not built in this configuration.
`endif

endmodule : fetch_queue
